qam_symbol_packer: RTL and testbench
====================================

QAM_SYMBOL_PACKER -- requirements
Module: qam_symbol_packer

Interface
REQ-001 The block SHALL have parameter SYMS_PER_FRAME, default 64, meaning demodulated symbols per OTFS frame; it SHALL be a multiple of 8, checked at elaboration.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 8, meaning output byte FIFO entries; it SHALL be a power of 2 and at least 2.
REQ-003 Clk  in  1  sole clock, all state on rising edge.
REQ-004 Rst_n  in  1  reset, asynchronous and active-low.
REQ-005 QAMDemodDataValid  in  1  symbol strobe from the 32-QAM demodulator.
REQ-006 QAMDemodData  in  5  demodulated symbol index 0..31.
REQ-007 ByteReady  in  1  downstream accepts ByteData this cycle.
REQ-008 ByteValid  out  1  FIFO head valid (first-word fall-through).
REQ-009 ByteData  out  8  packed byte, earliest symbol bit in bit 7.
REQ-010 ByteLast  out  1  ByteData is the final byte of a frame.
REQ-011 Overflow  out  1  sticky flag: a byte was dropped since reset.

Function
REQ-012 Symbols SHALL be appended MSB-first to a 12-bit accumulator with a 4-bit fill count (range 0..7 between cycles).
REQ-013 When fill plus 5 reaches 8 or more, the top 8 bits SHALL be written to the FIFO on the same edge that samples the symbol; the remainder SHALL stay left-aligned. At most one byte SHALL be produced per symbol.
REQ-014 Latency SHALL be 1 cycle: ByteValid is high after the edge that samples the completing symbol, if the FIFO was empty.
REQ-015 A 1-based symbol counter SHALL mark the byte completing symbol SYMS_PER_FRAME as ByteLast=1. The counter SHALL then wrap to 0, and the fill count SHALL be 0 at that point.
REQ-016 A FIFO pop SHALL occur when ByteValid and ByteReady are both high; ByteData and ByteLast SHALL hold while ByteValid=1 and ByteReady=0.
REQ-017 A push and a pop in the same cycle on a full FIFO SHALL both succeed, with no overflow.
REQ-018 The FSM SHALL have two states, PACK and RESYNC; reset enters PACK.
REQ-019 In PACK, a byte that must be written while the FIFO is full and not popping SHALL be dropped. The FSM SHALL set Overflow, clear the accumulator and enter RESYNC.
REQ-020 In RESYNC, symbols SHALL be counted but not packed. On the symbol completing the frame, the FSM SHALL return to PACK with an empty accumulator; the next symbol starts a fresh frame.
REQ-021 In either state, QAMDemodDataValid=0 SHALL leave the accumulator, fill count, symbol counter and state unchanged.

Reset
REQ-022 While Rst_n=0 the block SHALL hold: ByteValid=0, ByteData=0, ByteLast=0, Overflow=0, FIFO empty, accumulator and counters 0, state PACK.
REQ-023 Reset asserted mid-frame SHALL discard all buffered bytes and partial bits; the first symbol after release SHALL be symbol 1 of a new frame.

Configuration
REQ-024 With QAM_PACKER_FRAME_CNT_EN defined, the block SHALL add output FrameCount (16 bits, reset 0). FrameCount SHALL increment, wrapping at 65535, whenever a ByteLast byte is popped.
REQ-025 Without QAM_PACKER_FRAME_CNT_EN, the FrameCount port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-026 Package otfs_pkg SHALL hold QAM_BITS_PER_SYM=5, BYTE_W=8 and the packer state enum {PACK, RESYNC}.
REQ-027 The FIFO SHALL be a separate sub-module packer_fifo, FWFT, 9 bits wide (ByteLast plus byte), with full and empty outputs.

Verification
REQ-028 Symbols 1, 2 with ByteReady=1 -> one byte 0x08 after the second symbol; residual bits "10", fill count 2.
REQ-029 Eight symbols of 31 -> five bytes 0xFF, fill count 0.
REQ-030 Full 64-symbol frame, ByteReady=1 -> 40 bytes; ByteLast=1 only on byte 40; FrameCount=1 when QAM_PACKER_FRAME_CNT_EN is defined.
REQ-031 ByteReady=0 for 10 produced bytes, FIFO_DEPTH=8 -> 8 bytes held and the 9th dropped; Overflow=1; remaining symbols of the frame ignored; next frame's first byte correct.
REQ-032 FIFO full, then a push and pop in the same cycle -> FIFO stays full, Overflow stays 0, byte order preserved.
REQ-033 Rst_n pulsed low after symbol 37 of a frame -> all outputs 0 immediately; next 64 symbols yield a clean 40-byte frame.

Source files
------------

// File: rtl/otfs_pkg.sv
// Shared constants and types for the OTFS receive back-end (32-QAM symbol packing).
package otfs_pkg;

  localparam int QAM_BITS_PER_SYM = 5;
  localparam int BYTE_W           = 8;
  // Worst case between cycles is 7 leftover bits plus one fresh symbol.
  localparam int ACC_W            = 12;
  localparam int FILL_W           = 4;

  typedef enum logic {
    PACK   = 1'b0,
    RESYNC = 1'b1
  } pack_state_e;

endpackage

// File: rtl/packer_fifo.sv
// First-word-fall-through FIFO; a push on a full FIFO succeeds only alongside a pop.
module packer_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/qam_symbol_packer.sv
// Packs 5-bit 32-QAM symbols MSB-first into bytes with frame marking and overflow resync.
// Optional FrameCount output is enabled by defining QAM_PACKER_FRAME_CNT_EN.
module qam_symbol_packer
  import otfs_pkg::*;
#(
  parameter int SYMS_PER_FRAME = 64,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        QAMDemodDataValid,
  input  logic [4:0]  QAMDemodData,
  input  logic        ByteReady,
  output logic        ByteValid,
  output logic [7:0]  ByteData,
  output logic        ByteLast,
  output logic        Overflow
`ifdef QAM_PACKER_FRAME_CNT_EN
  ,
  output logic [15:0] FrameCount
`endif
);

  localparam int CNT_W = $clog2(SYMS_PER_FRAME);

  if (SYMS_PER_FRAME % 8 != 0) begin : g_bad_frame
    $error("SYMS_PER_FRAME must be a multiple of 8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  pack_state_e       state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d, ins;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              frame_end, byte_rdy, pop, push;
  logic [BYTE_W:0]   push_data, fifo_dout;
  logic              fifo_full, fifo_empty;

  assign pop       = !fifo_empty && ByteReady;
  assign frame_end = (cnt_q == CNT_W'(SYMS_PER_FRAME - 1));
  assign byte_rdy  = (fill_q + FILL_W'(QAM_BITS_PER_SYM)) >= FILL_W'(BYTE_W);
  // New symbol lands directly below the bits already held.
  assign ins       = acc_q | ({QAMDemodData, (ACC_W - QAM_BITS_PER_SYM)'(0)} >> fill_q);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    push      = 1'b0;
    push_data = '0;
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    if (QAMDemodDataValid) begin
      cnt_d = frame_end ? '0 : cnt_q + CNT_W'(1);
      unique case (state_q)
        PACK: begin
          if (!byte_rdy) begin
            acc_d  = ins;
            fill_d = fill_q + FILL_W'(QAM_BITS_PER_SYM);
          end else if (fifo_full && !pop) begin
            // Dropped byte: skip the rest of this frame unless it just ended.
            ovf_d   = 1'b1;
            acc_d   = '0;
            fill_d  = '0;
            state_d = frame_end ? PACK : RESYNC;
          end else begin
            push      = 1'b1;
            push_data = {frame_end, ins[ACC_W-1 -: BYTE_W]};
            acc_d     = {ins[ACC_W-BYTE_W-1:0], BYTE_W'(0)};
            fill_d    = fill_q + FILL_W'(QAM_BITS_PER_SYM) - FILL_W'(BYTE_W);
          end
        end
        RESYNC: begin
          if (frame_end) begin
            state_d = PACK;
            acc_d   = '0;
            fill_d  = '0;
          end
        end
        default: state_d = PACK;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= PACK;
      acc_q   <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  packer_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W + 1)
  ) u_fifo (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ByteValid = !fifo_empty;
  assign ByteData  = fifo_dout[BYTE_W-1:0];
  assign ByteLast  = fifo_dout[BYTE_W];
  assign Overflow  = ovf_q;

`ifdef QAM_PACKER_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      frame_cnt_q <= '0;
    end else if (pop && fifo_dout[BYTE_W]) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign FrameCount = frame_cnt_q;
`endif

endmodule

// File: tb/tb_qam_symbol_packer.sv
// Self-checking bench for qam_symbol_packer: bit-queue reference model plus directed scenarios.
module tb_qam_symbol_packer;

  localparam int SYMS  = 64;
  localparam int DEPTH = 8;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       QAMDemodDataValid = 1'b0;
  logic [4:0] QAMDemodData = '0;
  logic       ByteReady = 1'b0;
  logic       ByteValid, ByteLast, Overflow;
  logic [7:0] ByteData;
`ifdef QAM_PACKER_FRAME_CNT_EN
  logic [15:0] FrameCount;
`endif

  qam_symbol_packer #(.SYMS_PER_FRAME(SYMS), .FIFO_DEPTH(DEPTH)) dut (
    .Clk               (Clk),
    .Rst_n             (Rst_n),
    .QAMDemodDataValid (QAMDemodDataValid),
    .QAMDemodData      (QAMDemodData),
    .ByteReady         (ByteReady),
    .ByteValid         (ByteValid),
    .ByteData          (ByteData),
    .ByteLast          (ByteLast),
    .Overflow          (Overflow)
`ifdef QAM_PACKER_FRAME_CNT_EN
    ,
    .FrameCount        (FrameCount)
`endif
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: a plain bit stream, chopped into bytes, held in a bounded queue.
  typedef struct {
    logic [7:0] d;
    logic       l;
  } ent_t;

  ent_t exp_q[$];
  bit   bits[$];
  int   m_cnt = 0;
  bit   m_resync = 0;
  bit   m_ovf = 0;
  int   m_fc = 0;

  initial forever begin
    @(posedge Clk or negedge Rst_n);
    if (!Rst_n) begin
      exp_q.delete(); bits.delete();
      m_cnt = 0; m_resync = 0; m_ovf = 0; m_fc = 0;
    end else begin
      if (exp_q.size() > 0 && ByteReady) begin
        if (exp_q[0].l) m_fc = (m_fc + 1) % 65536;
        void'(exp_q.pop_front());
      end
      if (QAMDemodDataValid) begin
        bit eof;
        m_cnt++;
        eof = (m_cnt == SYMS);
        if (!m_resync) begin
          for (int b = 4; b >= 0; b--) bits.push_back(QAMDemodData[b]);
          if (bits.size() >= 8) begin
            ent_t e;
            e.d = '0;
            for (int k = 0; k < 8; k++) e.d = {e.d[6:0], bits.pop_front()};
            e.l = eof;
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            else begin
              m_ovf = 1;
              bits.delete();
              if (!eof) m_resync = 1;
            end
          end
        end else if (eof) m_resync = 0;
        if (eof) begin
          m_cnt = 0;
          bits.delete();
        end
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  logic [7:0] obs_d[$];
  logic       obs_l[$];

  initial forever begin
    @(negedge Clk);
    check("valid", ByteValid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("data", ByteData, exp_q[0].d);
      check("last", ByteLast, exp_q[0].l);
    end
    check("overflow", Overflow, m_ovf);
`ifdef QAM_PACKER_FRAME_CNT_EN
    check("frame_count", FrameCount, m_fc);
`endif
    if (Rst_n && ByteValid && ByteReady) begin
      obs_d.push_back(ByteData);
      obs_l.push_back(ByteLast);
    end
  end

  task automatic cyc(input logic v, input logic [4:0] s, input logic r);
    QAMDemodDataValid = v;
    QAMDemodData      = s;
    ByteReady         = r;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    QAMDemodDataValid = 1'b0;
    #1;
    check("rst_valid", ByteValid, 1'b0);
    check("rst_data", ByteData, 8'h00);
    check("rst_last", ByteLast, 1'b0);
    check("rst_ovf", Overflow, 1'b0);
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    obs_d.delete();
    obs_l.delete();
  endtask

  task automatic drain();
    int n = 0;
    while (ByteValid && n < 100) begin
      cyc(1'b0, 5'd0, 1'b1);
      n++;
    end
    check("drain_timeout", ByteValid, 1'b0);
    repeat (2) cyc(1'b0, 5'd0, 1'b1);
  endtask

  task automatic send_frame(input int n, input int mul, input int add, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b1, 5'((i * mul + add) % 32), r);
  endtask

  int n_last;

  initial begin
    repeat (2) @(posedge Clk);
    #1;

    // Symbols 1, 2 -> 0x08, two residual bits "10".
    do_reset();
    cyc(1'b1, 5'd1, 1'b1);
    cyc(1'b1, 5'd2, 1'b1);
    check("t1_valid_latency", ByteValid, 1'b1);
    check("t1_data_latency", ByteData, 8'h08);
    drain();
    check("t1_bytes", obs_d.size(), 1);
    if (obs_d.size() > 0) check("t1_byte0", obs_d[0], 8'h08);
    check("t1_fill", dut.fill_q, 4'd2);
    check("t1_resid", dut.acc_q[11:10], 2'b10);

    // Eight symbols of 31 -> five 0xFF bytes, nothing left over.
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1'b1, 5'd31, 1'b1);
    drain();
    check("t2_bytes", obs_d.size(), 5);
    foreach (obs_d[i]) check("t2_ff", obs_d[i], 8'hFF);
    check("t2_fill", dut.fill_q, 4'd0);

    // Full frame with ready held high: 40 bytes, only the last marked.
    do_reset();
    send_frame(SYMS, 7, 3, 1'b1);
    drain();
    check("t3_bytes", obs_d.size(), 40);
    n_last = 0;
    foreach (obs_l[i]) n_last += int'(obs_l[i]);
    check("t3_nlast", n_last, 1);
    if (obs_l.size() == 40) check("t3_last40", obs_l[39], 1'b1);
`ifdef QAM_PACKER_FRAME_CNT_EN
    check("t3_fcount", FrameCount, 16'd1);
`endif

    // Backpressure overflow: 8 held, 9th dropped, rest of frame ignored.
    do_reset();
    send_frame(SYMS, 1, 1, 1'b0);
    check("t4_ovf", Overflow, 1'b1);
    check("t4_full", dut.fifo_full, 1'b1);
    drain();
    check("t4_held", obs_d.size(), 8);
    send_frame(SYMS, 1, 1, 1'b1);
    drain();
    check("t4_total", obs_d.size(), 48);
    if (obs_d.size() == 48) begin
      check("t4_first_old", obs_d[0], 8'h08);
      check("t4_next_first", obs_d[8], 8'h08);
      check("t4_next_last", obs_l[47], 1'b1);
    end
    check("t4_ovf_sticky", Overflow, 1'b1);

    // Push and pop together on a full FIFO.
    do_reset();
    send_frame(13, 1, 1, 1'b0);
    check("t5_full", dut.fifo_full, 1'b1);
    cyc(1'b1, 5'd14, 1'b0);
    cyc(1'b1, 5'd15, 1'b1);
    check("t5_still_full", dut.fifo_full, 1'b1);
    check("t5_no_ovf", Overflow, 1'b0);
    drain();
    check("t5_bytes", obs_d.size(), 9);
    if (obs_d.size() == 9) check("t5_byte0", obs_d[0], 8'h08);

    // Reset mid-frame after symbol 37, then a clean frame.
    do_reset();
    send_frame(37, 7, 3, 1'b1);
    check("t6_pre_valid", ByteValid, 1'b1);
    do_reset();
    send_frame(SYMS, 1, 1, 1'b1);
    drain();
    check("t6_bytes", obs_d.size(), 40);
    if (obs_d.size() == 40) begin
      check("t6_first", obs_d[0], 8'h08);
      check("t6_last40", obs_l[39], 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
